load_store_unit: RTL and testbench

Sequencer between the datapath and `data_memory`, directly upstream of it. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and computes the effective address as base + signed offset. Drives `data_memory`'s `signal_memread`/`signal_memwrite`/`address`/`data_to_write` with correctly timed strobes. Captures `data_out` for loads and presents it to register-file write-back over a second valid/ready handshake.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 107 ++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the execute-stage request, write-back and data_memory signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the surrounding datapath/memory.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int REG_IDX_WIDTH = 3
) ();
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_is_store;
    logic [ADDR_WIDTH-1:0]    req_base;
    logic [ADDR_WIDTH-1:0]    req_offset;
    logic [DATA_WIDTH-1:0]    req_store_data;
    logic [REG_IDX_WIDTH-1:0] req_dest_reg;
    logic                     mem_read;
    logic                     mem_write;
    logic [ADDR_WIDTH-1:0]    mem_address;
    logic [DATA_WIDTH-1:0]    mem_write_data;
    logic [DATA_WIDTH-1:0]    mem_read_data;
    logic                     wb_valid;
    logic                     wb_ready;
    logic [REG_IDX_WIDTH-1:0] wb_dest_reg;
    logic [DATA_WIDTH-1:0]    wb_data;
    logic                     busy;

    modport slave (
        input  req_valid, req_is_store, req_base, req_offset, req_store_data, req_dest_reg,
        input  mem_read_data, wb_ready,
        output req_ready, mem_read, mem_write, mem_address, mem_write_data,
        output wb_valid, wb_dest_reg, wb_data, busy
    );

    modport master (
        output req_valid, req_is_store, req_base, req_offset, req_store_data, req_dest_reg,
        output mem_read_data, wb_ready,
        input  req_ready, mem_read, mem_write, mem_address, mem_write_data,
        input  wb_valid, wb_dest_reg, wb_data, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: accepts one request at a time, strobes data_memory with base+offset,
// and hands load results to register write-back over a valid/ready handshake.
module load_store_unit #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int REG_IDX_WIDTH = 3,
    parameter int READ_LATENCY  = 1
) (
    input  logic              clock,
    input  logic              reset,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_STORE = 2'd1,
        S_LOAD  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LATENCY - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [REG_IDX_WIDTH-1:0] dest_q, dest_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

    // Next-state and datapath capture; address/store data only move on accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dest_d  = dest_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d = bus.req_base + bus.req_offset;
                    dest_d = bus.req_dest_reg;
                    cnt_d  = {CNT_W{1'b0}};
                    if (bus.req_is_store) begin
                        wdata_d = bus.req_store_data;
                        state_d = S_STORE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STORE: begin
                state_d = S_IDLE;
            end
            S_LOAD: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d = bus.mem_read_data;
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WB: begin
                if (bus.wb_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            dest_q  <= {REG_IDX_WIDTH{1'b0}};
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dest_q  <= dest_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes and handshakes decode the state register only, so no input-to-output paths exist.
    assign bus.req_ready      = (state_q == S_IDLE);
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.mem_write      = (state_q == S_STORE);
    assign bus.mem_read       = (state_q == S_LOAD);
    assign bus.wb_valid       = (state_q == S_WB);
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.wb_dest_reg    = dest_q;
    assign bus.wb_data        = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a data_memory model and a reference memory array.
module tb_load_store_unit;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int RW = 3;
    localparam int RL = 3;

    typedef struct packed {
        logic [2:0] dest;
        logic [7:0] data;
    } wb_t;

    logic clock = 1'b0;
    logic reset;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;
    int   wb_mode = 2;
    logic [7:0] last_addr;
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    wb_t        exp_q [$];

    always #5 clock = ~clock;

    load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_IDX_WIDTH(RW)) bus ();

    load_store_unit #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_IDX_WIDTH(RW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [7:0] seed(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    // data_memory model: synchronous write, combinational read
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_write_data;
        end
    end
    assign bus.mem_read_data = mem[bus.mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // write-back consumer: changes wb_ready just after each rising edge
    initial begin
        bus.wb_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (wb_mode)
                0:       bus.wb_ready = ($urandom_range(0, 2) != 0);
                1:       bus.wb_ready = 1'b0;
                default: bus.wb_ready = 1'b1;
            endcase
        end
    end

    // monitor: scoreboard pop on each write-back handshake, stability while stalled
    initial begin
        logic       prev_valid;
        logic       prev_hs;
        logic [7:0] prev_data;
        logic [2:0] prev_dest;
        wb_t        e;
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_data  = 8'h00;
        prev_dest  = 3'd0;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                prev_valid = 1'b0;
            end else begin
                check("strobe_exclusive", {31'd0, bus.mem_read & bus.mem_write}, 32'd0);
                if (bus.wb_valid) begin
                    if (prev_valid && !prev_hs) begin
                        check("wb_data_stable", bus.wb_data, prev_data);
                        check("wb_dest_stable", bus.wb_dest_reg, prev_dest);
                    end
                    if (bus.wb_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL wb_unexpected: got data %0h dest %0d expected no result",
                                     bus.wb_data, bus.wb_dest_reg);
                        end else begin
                            e = exp_q.pop_front();
                            check("wb_data", bus.wb_data, e.data);
                            check("wb_dest", bus.wb_dest_reg, e.dest);
                        end
                    end
                end
                prev_valid = bus.wb_valid;
                prev_hs    = bus.wb_valid & bus.wb_ready;
                prev_data  = bus.wb_data;
                prev_dest  = bus.wb_dest_reg;
            end
        end
    end

    // Issue one request from a falling edge; returns on a falling edge once the strobe phase is over.
    task automatic issue(input logic st, input logic [7:0] base, input logic [7:0] off,
                         input logic [7:0] data, input logic [2:0] dest);
        logic [7:0] ea;
        wb_t        e;
        int         n;
        ea = base + off;
        bus.req_is_store   = st;
        bus.req_base       = base;
        bus.req_offset     = off;
        bus.req_store_data = data;
        bus.req_dest_reg   = dest;
        bus.req_valid      = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 within 50 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        if (st) begin
            ref_mem[ea] = data;
        end else begin
            e.dest = dest;
            e.data = ref_mem[ea];
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.req_valid      = 1'b0;
        bus.req_base       = 8'($urandom);
        bus.req_offset     = 8'($urandom);
        bus.req_store_data = 8'($urandom);
        bus.req_dest_reg   = 3'($urandom);
        bus.req_is_store   = 1'($urandom);
        @(negedge clock);
        last_addr = bus.mem_address;
        if (st) begin
            check("st_write",     bus.mem_write, 1);
            check("st_read",      bus.mem_read, 0);
            check("st_addr",      bus.mem_address, ea);
            check("st_data",      bus.mem_write_data, data);
            check("st_ready_low", bus.req_ready, 0);
            check("st_busy",      bus.busy, 1);
            @(negedge clock);
            check("st_write_end", bus.mem_write, 0);
            check("st_ready_ret", bus.req_ready, 1);
            check("st_addr_hold", bus.mem_address, ea);
        end else begin
            for (int k = 0; k < RL; k++) begin
                if (k != 0) @(negedge clock);
                check("ld_read",   bus.mem_read, 1);
                check("ld_write",  bus.mem_write, 0);
                check("ld_addr",   bus.mem_address, ea);
                check("ld_no_wb",  bus.wb_valid, 0);
            end
            @(negedge clock);
            check("ld_read_end", bus.mem_read, 0);
            check("ld_wb_valid", bus.wb_valid, 1);
            check("ld_addr_hold", bus.mem_address, ea);
        end
    endtask

    initial begin
        int n;
        reset              = 1'b1;
        mem_init           = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_is_store   = 1'b0;
        bus.req_base       = 8'h00;
        bus.req_offset     = 8'h00;
        bus.req_store_data = 8'h00;
        bus.req_dest_reg   = 3'd0;
        last_addr          = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        repeat (3) @(negedge clock);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_mem_read",  bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_addr",      bus.mem_address, 0);
        check("rst_wdata",     bus.mem_write_data, 0);
        check("rst_wb_valid",  bus.wb_valid, 0);
        check("rst_wb_dest",   bus.wb_dest_reg, 0);
        check("rst_wb_data",   bus.wb_data, 0);
        check("rst_busy",      bus.busy, 0);
        reset    = 1'b0;
        mem_init = 1'b0;

        // store then load of the same word, consumer always ready
        wb_mode = 2;
        issue(1'b1, 8'h00, 8'h00, 8'h0F, 3'd0);
        issue(1'b0, 8'h00, 8'h00, 8'h00, 3'd3);
        issue(1'b1, 8'h20, 8'h00, 8'hA5, 3'd0);
        issue(1'b0, 8'h10, 8'h10, 8'h00, 3'd5);

        // address wrap in both directions
        issue(1'b0, 8'hFE, 8'h05, 8'h00, 3'd1);
        check("addr_wrap_up", last_addr, 8'h03);
        issue(1'b1, 8'h10, 8'hFF, 8'h77, 3'd2);
        check("addr_wrap_down", last_addr, 8'h0F);

        // write-back stall with a pending store held by the requester
        wb_mode = 1;
        issue(1'b0, 8'h20, 8'h00, 8'h00, 3'd6);
        bus.req_is_store   = 1'b1;
        bus.req_base       = 8'h30;
        bus.req_offset     = 8'h00;
        bus.req_store_data = 8'h3C;
        bus.req_dest_reg   = 3'd0;
        bus.req_valid      = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("hold_wb_valid", bus.wb_valid, 1);
            check("hold_wb_data",  bus.wb_data, 8'hA5);
            check("hold_wb_dest",  bus.wb_dest_reg, 6);
            check("hold_ready",    bus.req_ready, 0);
            check("hold_no_write", bus.mem_write, 0);
        end
        wb_mode = 2;
        n = 0;
        while (bus.wb_valid && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("release_wb_valid", bus.wb_valid, 0);
        check("release_ready",    bus.req_ready, 1);
        check("release_no_write", bus.mem_write, 0);
        issue(1'b1, 8'h30, 8'h00, 8'h3C, 3'd0);

        // reset in the middle of a load
        bus.req_is_store = 1'b0;
        bus.req_base     = 8'h40;
        bus.req_offset   = 8'h01;
        bus.req_dest_reg = 3'd7;
        bus.req_valid    = 1'b1;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        check("mid_load_read", bus.mem_read, 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_ld_read",     bus.mem_read, 0);
        check("rst_ld_wb_valid", bus.wb_valid, 0);
        check("rst_ld_ready",    bus.req_ready, 1);
        check("rst_ld_addr",     bus.mem_address, 0);
        check("rst_ld_busy",     bus.busy, 0);
        check("rst_ld_wb_data",  bus.wb_data, 0);
        repeat (RL + 3) begin
            @(negedge clock);
            check("rst_ld_no_wb", bus.wb_valid, 0);
        end
        issue(1'b0, 8'h30, 8'h00, 8'h00, 3'd4);

        // randomized mix with a randomly stalling consumer
        for (int i = 0; i < 60; i++) begin
            wb_mode = ($urandom_range(0, 3) == 0) ? 2 : 0;
            repeat ($urandom_range(0, 2)) @(negedge clock);
            issue(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 3'($urandom));
        end

        wb_mode = 2;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("scoreboard_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
